// File: rtl/mbist_fail_log.sv
// mbist_fail_log: captures the first DEPTH MBIST failing addresses and streams them out after bist_done.
// Define MBIST_FAIL_LOG_ELEM_EN to also log the march element index (rd_elem).
module mbist_fail_log #(
    parameter int ADDR  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             fault_flag,
    input  logic [ADDR-1:0]  addr,
    input  logic             addr_done,
    input  logic             bist_done,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [ADDR-1:0]  rd_addr,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             overflow,
    output logic             log_done,
    output logic             pass
`ifdef MBIST_FAIL_LOG_ELEM_EN
    ,
    output logic [2:0]       rd_elem
`endif
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, REPORT} state_t;

    state_t          state, nxt;
    logic [PW:0]     wr_ptr, rd_ptr;
    logic [ADDR-1:0] addr_d;
    logic [ADDR-1:0] log_mem [DEPTH];
    logic            cap, full, wr_en, rd_en;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb
        nxt = !mode ? IDLE :
              state == IDLE ? CAPTURE :
              (state == CAPTURE && bist_done) ? REPORT : state;

    // fault_flag refers to the previous address, so captures use addr_d; dropping mode wins over a fault
    always_comb begin
        cap      = state == CAPTURE && mode && fault_flag;
        full     = wr_ptr == (PW+1)'(DEPTH);
        wr_en    = cap && !full;
        rd_valid = state == REPORT && rd_ptr != wr_ptr;
        rd_en    = rd_valid && rd_ready;
        rd_addr  = rd_valid ? log_mem[rd_ptr[PW-1:0]] : '0;
        log_done = state == REPORT && !rd_valid;
        pass     = state == REPORT && fail_cnt == '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) addr_d <= '0;
        else        addr_d <= addr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fail_cnt <= '0;
            overflow <= 1'b0;
        end else if (!mode) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fail_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)               wr_ptr   <= wr_ptr + 1'b1;
            if (rd_en)               rd_ptr   <= rd_ptr + 1'b1;
            if (cap && full)         overflow <= 1'b1;
            if (cap && !(&fail_cnt)) fail_cnt <= fail_cnt + 1'b1;
        end

    always_ff @(posedge clk)
        if (wr_en) log_mem[wr_ptr[PW-1:0]] <= addr_d;

`ifdef MBIST_FAIL_LOG_ELEM_EN
    logic [2:0] elem, elem_d;
    logic [2:0] elem_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            elem   <= '0;
            elem_d <= '0;
        end else begin
            elem_d <= elem;
            if (!mode)                                         elem <= '0;
            else if (state == CAPTURE && addr_done && elem != 3'd7) elem <= elem + 1'b1;
        end

    always_ff @(posedge clk)
        if (wr_en) elem_mem[wr_ptr[PW-1:0]] <= elem_d;

    assign rd_elem = rd_valid ? elem_mem[rd_ptr[PW-1:0]] : '0;
`else
    logic unused_addr_done;
    assign unused_addr_done = addr_done;
`endif
endmodule

// File: tb/tb_mbist_fail_log.sv
// tb_mbist_fail_log: scenario tasks plus a queue scoreboard checking logged addresses in read order.
module tb_mbist_fail_log;
    localparam int DEPTH = 4;

    logic       clk = 0, rst_n = 0, mode = 0, fault_flag = 0, addr_done = 0, bist_done = 0, rd_ready = 0;
    logic [7:0] addr = 0;
    logic       rd_valid, overflow, log_done, pass;
    logic [7:0] rd_addr, fail_cnt;
`ifdef MBIST_FAIL_LOG_ELEM_EN
    logic [2:0] rd_elem;
`endif

    int         total = 0, bad = 0;
    logic [7:0] q[$];
    logic [7:0] prev_a = 0, exp_a;
    int         m_cnt = 0, m_fail = 0;
    logic       m_ovf = 0;

    mbist_fail_log dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .fault_flag(fault_flag), .addr(addr),
        .addr_done(addr_done), .bist_done(bist_done), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .fail_cnt(fail_cnt), .overflow(overflow),
        .log_done(log_done), .pass(pass)
`ifdef MBIST_FAIL_LOG_ELEM_EN
        , .rd_elem(rd_elem)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every accepted entry must match the oldest expected address
    always @(negedge clk)
        if (rst_n && rd_valid && rd_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got entry %h, expected none", rd_addr);
            end else begin
                exp_a = q.pop_front();
                if (rd_addr !== exp_a) begin
                    bad++;
                    $display("FAIL sb_addr: got %h exp %h", rd_addr, exp_a);
                end
            end
        end

    task automatic tick();
        @(posedge clk);
        prev_a = addr;
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic f);
        addr       = a;
        fault_flag = f;
        if (f) begin
            m_fail++;
            if (m_cnt < DEPTH) begin
                q.push_back(prev_a);
                m_cnt++;
            end else m_ovf = 1;
        end
        tick();
        fault_flag = 0;
    endtask

    task automatic clear_model();
        q.delete();
        m_cnt = 0; m_fail = 0; m_ovf = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #2;
        total++; if ({rd_valid, rd_addr, overflow} !== 10'd0) begin bad++; $display("FAIL reset_rd: got %b exp 0", {rd_valid, rd_addr, overflow}); end
        total++; if (fail_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %h exp 0", fail_cnt); end
        total++; if ({log_done, pass} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b exp 00", {log_done, pass}); end
        tick(); tick();
        rst_n = 1;
        tick();
        total++; if ({log_done, pass, rd_valid} !== 3'b000) begin bad++; $display("FAIL idle_flags: got %b exp 000", {log_done, pass, rd_valid}); end
    endtask

    task automatic test_pass();
        clear_model();
        mode = 1; tick();
        drive(8'h10, 0); drive(8'h11, 0);
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL pass_early: got %b exp 0", pass); end
        bist_done = 1; drive(8'h12, 0); bist_done = 0;
        total++; if ({pass, log_done, rd_valid} !== 3'b110) begin bad++; $display("FAIL pass_report: got %b exp 110", {pass, log_done, rd_valid}); end
        total++; if (fail_cnt !== 8'd0) begin bad++; $display("FAIL pass_cnt: got %h exp 0", fail_cnt); end
        mode = 0; tick();
    endtask

    task automatic test_single();
        clear_model();
        mode = 1; tick();
        drive(8'h15, 0); drive(8'h00, 1);
        bist_done = 1; drive(8'h00, 0); bist_done = 0;
        total++; if ({rd_valid, rd_addr} !== {1'b1, 8'h15}) begin bad++; $display("FAIL single_head: got %b/%h exp 1/15", rd_valid, rd_addr); end
        total++; if (fail_cnt !== 8'(m_fail)) begin bad++; $display("FAIL single_cnt: got %h exp %h", fail_cnt, 8'(m_fail)); end
        total++; if ({pass, overflow, log_done} !== 3'b000) begin bad++; $display("FAIL single_flags: got %b exp 000", {pass, overflow, log_done}); end
        rd_ready = 1; tick(); rd_ready = 0;
        total++; if ({log_done, rd_valid} !== 2'b10 || q.size() != 0) begin bad++; $display("FAIL single_done: got %b left %0d exp 10 left 0", {log_done, rd_valid}, q.size()); end
        mode = 0; tick();
    endtask

    task automatic test_back_to_back_overflow();
        clear_model();
        mode = 1; tick();
        drive(8'h01, 0);
        for (int i = 2; i <= 6; i++) drive(8'(i), 1);
        bist_done = 1; drive(8'h00, 1); bist_done = 0;
        total++; if (fail_cnt !== 8'(m_fail)) begin bad++; $display("FAIL ovf_cnt: got %h exp %h", fail_cnt, 8'(m_fail)); end
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag: got %b exp %b", overflow, m_ovf); end
        rd_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: cycle %0d got %b exp 1", i, rd_valid); end
            tick();
        end
        rd_ready = 0;
        total++; if (log_done !== 1'b1 || q.size() != 0) begin bad++; $display("FAIL ovf_done: got %b left %0d exp 1 left 0", log_done, q.size()); end
        mode = 0; tick();
    endtask

    task automatic test_last_read_backpressure();
        clear_model();
        mode = 1; tick();
        drive(8'h20, 0); drive(8'hFF, 1);
        bist_done = 1; drive(8'h00, 1); bist_done = 0;
        fault_flag = 1; tick(); fault_flag = 0;
        total++; if (fail_cnt !== 8'(m_fail)) begin bad++; $display("FAIL report_ignore: got %h exp %h", fail_cnt, 8'(m_fail)); end
        repeat (3) tick();
        total++; if ({rd_valid, rd_addr} !== {1'b1, 8'h20}) begin bad++; $display("FAIL hold_addr: got %b/%h exp 1/20", rd_valid, rd_addr); end
        rd_ready = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        rd_ready = 0;
        total++; if (log_done !== 1'b1 || q.size() != 0) begin bad++; $display("FAIL last_done: got %b left %0d exp 1 left 0", log_done, q.size()); end
        mode = 0; tick();
    endtask

    task automatic test_abort();
        clear_model();
        mode = 1; tick();
        drive(8'h03, 0); drive(8'h04, 1);
        bist_done = 1; drive(8'h00, 0); bist_done = 0;
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL abort_pre: got %b exp 1", rd_valid); end
        mode = 0; tick(); clear_model();
        total++; if ({rd_valid, rd_addr, fail_cnt, overflow, log_done, pass} !== 20'd0) begin bad++; $display("FAIL abort_clear: got %h exp 0", {rd_valid, rd_addr, fail_cnt, overflow, log_done, pass}); end
        mode = 1; tick();
        drive(8'h07, 0);
        mode = 0; fault_flag = 1; tick(); fault_flag = 0;
        mode = 1; tick();
        bist_done = 1; tick(); bist_done = 0;
        total++; if ({pass, rd_valid, fail_cnt} !== {2'b10, 8'd0}) begin bad++; $display("FAIL mode_fault: got %b/%b/%h exp 1/0/00", pass, rd_valid, fail_cnt); end
        mode = 0; tick();
    endtask

    task automatic test_async_reset();
        clear_model();
        mode = 1; tick();
        drive(8'h09, 0); drive(8'h00, 1);
        total++; if (fail_cnt !== 8'd1) begin bad++; $display("FAIL areset_pre: got %h exp 01", fail_cnt); end
        #2 rst_n = 0;
        #1;
        total++; if ({fail_cnt, rd_valid, pass, log_done} !== 11'd0) begin bad++; $display("FAIL areset_clear: got %h exp 0", {fail_cnt, rd_valid, pass, log_done}); end
        clear_model();
        mode = 0; tick();
        rst_n = 1; tick();
    endtask

`ifdef MBIST_FAIL_LOG_ELEM_EN
    task automatic test_elem();
        clear_model();
        mode = 1; tick();
        addr_done = 1; drive(8'h30, 0); drive(8'h31, 0); addr_done = 0;
        drive(8'h40, 1); drive(8'h41, 0); drive(8'h42, 1);
        bist_done = 1; drive(8'h00, 0); bist_done = 0;
        total++; if (rd_elem !== 3'd1) begin bad++; $display("FAIL elem_first: got %0d exp 1", rd_elem); end
        rd_ready = 1; tick(); rd_ready = 0;
        total++; if (rd_elem !== 3'd2) begin bad++; $display("FAIL elem_second: got %0d exp 2", rd_elem); end
        rd_ready = 1; tick(); rd_ready = 0;
        mode = 0; tick();
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_single();
        test_back_to_back_overflow();
        test_last_read_backpressure();
        test_abort();
        test_async_reset();
`ifdef MBIST_FAIL_LOG_ELEM_EN
        test_elem();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
